// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - single-port RAM sequencer/arbiter for IF and MEM with stack push/pop
module mem_port_sched #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = 12'hFFF,
    parameter logic [31:0]       INT_VEC  = 32'h0000_0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [15:0]       op_wdata,
    input  logic [31:0]       op_pc,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic              rd_valid,
    output logic              jump_call,
    output logic              jump_ret,
    output logic [31:0]       jump_target,
    output logic [ADDR_W-1:0] sp
);

    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ST   = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_LO  = 2'd1,
        POP_HI   = 2'd2,
        POP_DONE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] sp_n;
    logic [15:0]       lo_q, lo_n;
    logic              rd_pend, rd_pend_n;
    logic              mem_use;
    logic [ADDR_W-1:0] sp_inc, sp_dec;

    // Stack pointer neighbours; wrap modulo 2^ADDR_W is intentional and silent.
    assign sp_inc = sp + SP_ONE;
    assign sp_dec = sp - SP_ONE;

    // State, stack pointer, low-half pop latch and LD-pending flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sp      <= SP_RESET;
            lo_q    <= 16'h0000;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_n;
            sp      <= sp_n;
            lo_q    <= lo_n;
            rd_pend <= rd_pend_n;
        end
    end

    // Sequence MEM operations, give leftover RAM cycles to fetch, drive pipeline controls.
    always_comb begin
        state_n     = state;
        sp_n        = sp;
        lo_n        = lo_q;
        rd_pend_n   = 1'b0;
        mem_use     = 1'b0;
        mem_stall   = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = 16'h0000;
        jump_call   = 1'b0;
        jump_ret    = 1'b0;
        jump_target = 32'h0000_0000;
        if_grant    = 1'b0;
        if_stall    = 1'b0;
        rd_valid    = rd_pend;

        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_LD: begin
                            mem_use   = 1'b1;
                            ram_en    = 1'b1;
                            ram_addr  = op_addr;
                            rd_pend_n = 1'b1;
                        end
                        OP_ST: begin
                            mem_use   = 1'b1;
                            ram_en    = 1'b1;
                            ram_we    = 1'b1;
                            ram_addr  = op_addr;
                            ram_wdata = op_wdata;
                        end
                        OP_CALL, OP_INT: begin
                            mem_use   = 1'b1;
                            ram_en    = 1'b1;
                            ram_we    = 1'b1;
                            ram_addr  = sp;
                            ram_wdata = op_pc[31:16];
                            sp_n      = sp_dec;
                            mem_stall = 1'b1;
                            state_n   = PUSH_LO;
                        end
                        OP_RET: begin
                            mem_use   = 1'b1;
                            ram_en    = 1'b1;
                            ram_addr  = sp_inc;
                            sp_n      = sp_inc;
                            mem_stall = 1'b1;
                            state_n   = POP_HI;
                        end
                        default: ;
                    endcase
                end
            end
            PUSH_LO: begin
                mem_use   = 1'b1;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = sp;
                ram_wdata = op_pc[15:0];
                sp_n      = sp_dec;
                jump_call = 1'b1;
                if (op == OP_INT) begin
                    jump_target = INT_VEC;
                end
                state_n   = IDLE;
            end
            POP_HI: begin
                mem_use   = 1'b1;
                ram_en    = 1'b1;
                ram_addr  = sp_inc;
                sp_n      = sp_inc;
                lo_n      = ram_rdata;
                mem_stall = 1'b1;
                state_n   = POP_DONE;
            end
            POP_DONE: begin
                jump_ret    = 1'b1;
                jump_target = {ram_rdata, lo_q};
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (if_req && !mem_use) begin
            if_grant = 1'b1;
            ram_en   = 1'b1;
            ram_we   = 1'b0;
            ram_addr = if_addr;
        end
        if_stall = if_req && !if_grant;

        // While reset is held nothing may touch the RAM or pulse the pipeline.
        if (!rst) begin
            mem_stall   = 1'b0;
            ram_en      = 1'b0;
            ram_we      = 1'b0;
            ram_addr    = '0;
            ram_wdata   = 16'h0000;
            jump_call   = 1'b0;
            jump_ret    = 1'b0;
            jump_target = 32'h0000_0000;
            if_grant    = 1'b0;
            if_stall    = 1'b0;
            rd_valid    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - directed self-checking bench for mem_port_sched
module tb_mem_port_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [11:0] op_addr = 12'h000;
    logic [15:0] op_wdata = 16'h0000;
    logic [31:0] op_pc = 32'h0;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = 12'h000;
    logic        if_grant, if_stall, mem_stall, ram_en, ram_we, rd_valid, jump_call, jump_ret;
    logic [11:0] ram_addr, sp;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;
    logic [31:0] jump_target;

    logic        w2_if_grant, w2_if_stall, w2_mem_stall, w2_ram_en, w2_ram_we, w2_rd_valid;
    logic        w2_jump_call, w2_jump_ret;
    logic [11:0] w2_ram_addr, w2_sp;
    logic [15:0] w2_ram_wdata;
    logic [31:0] w2_jump_target;

    logic [15:0] mem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_sched dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_addr(op_addr),
        .op_wdata(op_wdata), .op_pc(op_pc), .if_req(if_req), .if_addr(if_addr),
        .if_grant(if_grant), .if_stall(if_stall), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .rd_valid(rd_valid), .jump_call(jump_call),
        .jump_ret(jump_ret), .jump_target(jump_target), .sp(sp)
    );

    mem_port_sched #(.SP_RESET(12'h000)) dut_wrap (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_addr(op_addr),
        .op_wdata(op_wdata), .op_pc(op_pc), .if_req(if_req), .if_addr(if_addr),
        .if_grant(w2_if_grant), .if_stall(w2_if_stall), .mem_stall(w2_mem_stall),
        .ram_en(w2_ram_en), .ram_we(w2_ram_we), .ram_addr(w2_ram_addr),
        .ram_wdata(w2_ram_wdata), .ram_rdata(ram_rdata), .rd_valid(w2_rd_valid),
        .jump_call(w2_jump_call), .jump_ret(w2_jump_ret), .jump_target(w2_jump_target),
        .sp(w2_sp)
    );

    // Synchronous single-port RAM model: read data appears the cycle after the request.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [2:0] o, input logic [31:0] pc);
        op_valid = v;
        op       = o;
        op_pc    = pc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (sp !== 12'hFFF) begin n_err++; $display("FAIL reset_sp: got %h want fff", sp); end
        n_cmp++; if ({ram_en, ram_we, mem_stall, if_grant, if_stall, rd_valid, jump_call, jump_ret} !== 8'h00)
            begin n_err++; $display("FAIL reset_ctrl: got %b want 00000000", {ram_en, ram_we, mem_stall, if_grant, if_stall, rd_valid, jump_call, jump_ret}); end
        n_cmp++; if (jump_target !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h want 0", jump_target); end
        next_cycle();
        rst = 1'b1;
        set_op(1'b1, 3'd5, 32'h0);
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL rstret_stall: got %b want 1", mem_stall); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (sp !== 12'h000) begin n_err++; $display("FAIL rstret_sp_pophi: got %h want 000", sp); end
        rst = 1'b0;
        #1;
        n_cmp++; if (sp !== 12'hFFF) begin n_err++; $display("FAIL rstret_sp_abort: got %h want fff", sp); end
        n_cmp++; if ({jump_ret, ram_en, mem_stall} !== 3'b000) begin n_err++; $display("FAIL rstret_ctrl: got %b want 000", {jump_ret, ram_en, mem_stall}); end
        set_op(1'b0, 3'd0, 32'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({jump_ret, jump_call, ram_en} !== 3'b000) begin n_err++; $display("FAIL rstret_nojump: got %b want 000", {jump_ret, jump_call, ram_en}); end
        n_cmp++; if (sp !== 12'hFFF) begin n_err++; $display("FAIL rstret_sp_after: got %h want fff", sp); end
    endtask

    task automatic test_call();
        next_cycle();
        set_op(1'b1, 3'd3, 32'h1234_5678);
        if_req  = 1'b1;
        if_addr = 12'h100;
        @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'hFFF, 16'h1234})
            begin n_err++; $display("FAIL call_c1_write: got %b %b %h %h want 1 1 fff 1234", ram_en, ram_we, ram_addr, ram_wdata); end
        n_cmp++; if ({mem_stall, jump_call, if_grant, if_stall} !== 4'b1001)
            begin n_err++; $display("FAIL call_c1_ctrl: got %b want 1001", {mem_stall, jump_call, if_grant, if_stall}); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'hFFE, 16'h5678})
            begin n_err++; $display("FAIL call_c2_write: got %b %b %h %h want 1 1 ffe 5678", ram_en, ram_we, ram_addr, ram_wdata); end
        n_cmp++; if ({mem_stall, jump_call, if_grant, if_stall} !== 4'b0101)
            begin n_err++; $display("FAIL call_c2_ctrl: got %b want 0101", {mem_stall, jump_call, if_grant, if_stall}); end
        n_cmp++; if (jump_target !== 32'h0) begin n_err++; $display("FAIL call_target: got %h want 0", jump_target); end
        next_cycle();
        set_op(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (sp !== 12'hFFD) begin n_err++; $display("FAIL call_sp: got %h want ffd", sp); end
        n_cmp++; if ({if_grant, if_stall, ram_en, ram_we, ram_addr} !== {4'b1010, 12'h100})
            begin n_err++; $display("FAIL nop_fetch: got %b %b %b %b %h want 1 0 1 0 100", if_grant, if_stall, ram_en, ram_we, ram_addr); end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fetch_no_rdvalid: got %b want 0", rd_valid); end
    endtask

    task automatic test_ret();
        next_cycle();
        set_op(1'b1, 3'd5, 32'h0);
        if_req  = 1'b1;
        if_addr = 12'h101;
        @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, ram_addr, mem_stall, if_grant} !== {2'b10, 12'hFFE, 2'b10})
            begin n_err++; $display("FAIL ret_c1: got %b %b %h %b %b want 1 0 ffe 1 0", ram_en, ram_we, ram_addr, mem_stall, if_grant); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, ram_addr, mem_stall, if_grant} !== {2'b10, 12'hFFF, 2'b10})
            begin n_err++; $display("FAIL ret_c2: got %b %b %h %b %b want 1 0 fff 1 0", ram_en, ram_we, ram_addr, mem_stall, if_grant); end
        n_cmp++; if (jump_ret !== 1'b0) begin n_err++; $display("FAIL ret_c2_early: got %b want 0", jump_ret); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({jump_ret, mem_stall, jump_target} !== {2'b10, 32'h1234_5678})
            begin n_err++; $display("FAIL ret_c3_jump: got %b %b %h want 1 0 12345678", jump_ret, mem_stall, jump_target); end
        n_cmp++; if ({if_grant, ram_addr, rd_valid} !== {1'b1, 12'h101, 1'b0})
            begin n_err++; $display("FAIL ret_c3_fetch: got %b %h %b want 1 101 0", if_grant, ram_addr, rd_valid); end
        next_cycle();
        set_op(1'b0, 3'd0, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++; if ({sp, jump_ret} !== {12'hFFF, 1'b0}) begin n_err++; $display("FAIL ret_sp: got %h %b want fff 0", sp, jump_ret); end
    endtask

    task automatic test_int();
        next_cycle();
        set_op(1'b1, 3'd4, 32'hAAAA_0004);
        @(negedge clk);
        n_cmp++; if ({ram_we, ram_addr, ram_wdata, mem_stall} !== {1'b1, 12'hFFF, 16'hAAAA, 1'b1})
            begin n_err++; $display("FAIL int_c1: got %b %h %h %b want 1 fff aaaa 1", ram_we, ram_addr, ram_wdata, mem_stall); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({ram_we, ram_addr, ram_wdata, jump_call} !== {1'b1, 12'hFFE, 16'h0004, 1'b1})
            begin n_err++; $display("FAIL int_c2: got %b %h %h %b want 1 ffe 0004 1", ram_we, ram_addr, ram_wdata, jump_call); end
        n_cmp++; if (jump_target !== 32'h0000_0010) begin n_err++; $display("FAIL int_target: got %h want 00000010", jump_target); end
        next_cycle();
        set_op(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({sp, mem[12'hFFF], mem[12'hFFE]} !== {12'hFFD, 16'hAAAA, 16'h0004})
            begin n_err++; $display("FAIL int_stack: got %h %h %h want ffd aaaa 0004", sp, mem[12'hFFF], mem[12'hFFE]); end
    endtask

    task automatic test_ld_st();
        next_cycle();
        set_op(1'b1, 3'd2, 32'h0);
        op_addr  = 12'h020;
        op_wdata = 16'hBEEF;
        next_cycle();
        set_op(1'b1, 3'd1, 32'h0);
        op_addr = 12'h020;
        if_req  = 1'b1;
        if_addr = 12'h102;
        @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, ram_addr, mem_stall, rd_valid} !== {2'b10, 12'h020, 2'b00})
            begin n_err++; $display("FAIL ld_issue: got %b %b %h %b %b want 1 0 020 0 0", ram_en, ram_we, ram_addr, mem_stall, rd_valid); end
        n_cmp++; if ({if_grant, if_stall} !== 2'b01) begin n_err++; $display("FAIL ld_if_stall: got %b want 01", {if_grant, if_stall}); end
        next_cycle();
        set_op(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({rd_valid, ram_rdata} !== {1'b1, 16'hBEEF}) begin n_err++; $display("FAIL ld_data: got %b %h want 1 beef", rd_valid, ram_rdata); end
        n_cmp++; if (if_grant !== 1'b1) begin n_err++; $display("FAIL ld_if_resume: got %b want 1", if_grant); end
        next_cycle();
        if_req = 1'b0;
        set_op(1'b1, 3'd2, 32'h0);
        op_addr  = 12'h021;
        op_wdata = 16'h00FF;
        @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, ram_addr, ram_wdata, mem_stall} !== {2'b11, 12'h021, 16'h00FF, 1'b0})
            begin n_err++; $display("FAIL st_write: got %b %b %h %h %b want 1 1 021 00ff 0", ram_en, ram_we, ram_addr, ram_wdata, mem_stall); end
        next_cycle();
        set_op(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({rd_valid, ram_en, mem[12'h021]} !== {2'b00, 16'h00FF})
            begin n_err++; $display("FAIL st_done: got %b %b %h want 0 0 00ff", rd_valid, ram_en, mem[12'h021]); end
    endtask

    task automatic test_wrap();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        set_op(1'b1, 3'd3, 32'h0000_0000);
        @(negedge clk);
        n_cmp++; if ({w2_sp, w2_ram_addr, w2_ram_we} !== {12'h000, 12'h000, 1'b1})
            begin n_err++; $display("FAIL wrap_c1: got %h %h %b want 000 000 1", w2_sp, w2_ram_addr, w2_ram_we); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({w2_ram_addr, w2_jump_call} !== {12'hFFF, 1'b1})
            begin n_err++; $display("FAIL wrap_c2: got %h %b want fff 1", w2_ram_addr, w2_jump_call); end
        next_cycle();
        set_op(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({w2_sp, sp} !== {12'hFFE, 12'hFFD}) begin n_err++; $display("FAIL wrap_sp: got %h %h want ffe ffd", w2_sp, sp); end
    endtask

    initial begin
        test_reset();
        test_call();
        test_ret();
        test_int();
        test_ld_st();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
